card_cmd_parser: RTL and testbench

Byte-stream command parser between the UART receive channel and the SD card driver's request channels. Decodes read/write commands with a big-endian block address, issues WR/RD strobes, and streams a fixed-length write payload into the WD channel. Adds inter-byte timeout recovery with zero-padding so the card driver is never left stalled mid-block.

---
 rtl/card_cmd_pkg.sv | 21 ++
 rtl/idle_timer.sv | 37 +++
 rtl/card_cmd_parser.sv | 184 ++++++++++++++++++
 tb/tb_card_cmd_parser.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/card_cmd_pkg.sv
// Shared types and constants for the card command parser.
package card_cmd_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StIssueWr,
    StIssueRd,
    StWdata,
    StPad
  } state_e;

  localparam logic [1:0] ErrNone        = 2'd0;
  localparam logic [1:0] ErrBadOpcode   = 2'd1;
  localparam logic [1:0] ErrAddrTimeout = 2'd2;
  localparam logic [1:0] ErrDataTimeout = 2'd3;

  localparam logic [7:0] DefCmdWr = 8'h57;
  localparam logic [7:0] DefCmdRd = 8'h52;

endpackage

// File: rtl/idle_timer.sv
// Inter-byte idle counter: pulses expire_o on the cycle the count sits at TIMEOUT_CYC-1
// while enabled, unless a clear arrives in the same cycle.
module idle_timer #(
  parameter int unsigned TIMEOUT_CYC = 50000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LastCnt = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire_o = en_i & ~clr_i & (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || expire_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/card_cmd_parser.sv
// UART byte-stream to SD card request parser: opcode, big-endian address, write payload,
// with inter-byte timeout recovery that zero-pads an unfinished write block.
module card_cmd_parser
  import card_cmd_pkg::*;
#(
  parameter int unsigned ADDR_BYTES  = 4,
  parameter int unsigned BLOCK_LEN   = 512,
  parameter int unsigned TIMEOUT_CYC = 50000000,
  parameter logic [7:0]  CMD_WR      = DefCmdWr,
  parameter logic [7:0]  CMD_RD      = DefCmdRd
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    rx_stb_i,
  input  logic [7:0]              rx_dat_i,
  output logic                    rx_ack_o,
  output logic                    wr_stb_o,
  output logic [8*ADDR_BYTES-1:0] wr_addr_o,
  input  logic                    wr_ack_i,
  output logic                    wd_stb_o,
  output logic [7:0]              wd_data_o,
  input  logic                    wd_ack_i,
  output logic                    rd_stb_o,
  output logic [8*ADDR_BYTES-1:0] rd_addr_o,
  input  logic                    rd_ack_i,
  output logic                    err_stb_o,
  output logic [1:0]              err_code_o,
  output logic                    busy_o
);

  localparam int unsigned AW  = 8 * ADDR_BYTES;
  localparam int unsigned BcW = $clog2(BLOCK_LEN + 1);
  localparam int unsigned AcW = $clog2(ADDR_BYTES + 1);
  localparam logic [BcW-1:0] LastByte = BcW'(BLOCK_LEN - 1);
  localparam logic [AcW-1:0] LastAddr = AcW'(ADDR_BYTES - 1);

  state_e         state_q;
  logic           mode_wr_q;
  logic [AW-1:0]  addr_q, wr_addr_q, rd_addr_q;
  logic [AcW-1:0] acnt_q;
  logic [BcW-1:0] bcnt_q;
  logic           wr_stb_q, rd_stb_q, wd_stb_q, err_stb_q;
  logic [7:0]     wd_data_q;
  logic [1:0]     err_code_q;

  logic          rx_fire;
  logic [AW-1:0] addr_shift;
  logic          tmr_en, tmr_clr, tmr_expire;

  always_comb begin
    rx_ack_o = 1'b0;
    unique case (state_q)
      StIdle, StAddr: rx_ack_o = 1'b1;
      StWdata:        rx_ack_o = ~wd_stb_q;
      default:        rx_ack_o = 1'b0;
    endcase
  end

  assign rx_fire    = rx_stb_i & rx_ack_o;
  assign addr_shift = (addr_q << 8) | AW'(rx_dat_i);

  // Frozen (neither enabled nor cleared) while a payload byte waits on the card driver.
  assign tmr_en  = (state_q == StAddr) | ((state_q == StWdata) & ~wd_stb_q);
  assign tmr_clr = rx_fire | ~((state_q == StAddr) | (state_q == StWdata));

  idle_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_idle_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (tmr_en),
    .clr_i   (tmr_clr),
    .expire_o(tmr_expire)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      mode_wr_q  <= 1'b0;
      addr_q     <= '0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      acnt_q     <= '0;
      bcnt_q     <= '0;
      wr_stb_q   <= 1'b0;
      rd_stb_q   <= 1'b0;
      wd_stb_q   <= 1'b0;
      wd_data_q  <= '0;
      err_stb_q  <= 1'b0;
      err_code_q <= ErrNone;
    end else begin
      err_stb_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rx_fire) begin
            if (rx_dat_i == CMD_WR || rx_dat_i == CMD_RD) begin
              mode_wr_q <= (rx_dat_i == CMD_WR);
              addr_q    <= '0;
              acnt_q    <= '0;
              state_q   <= StAddr;
            end else begin
              err_stb_q  <= 1'b1;
              err_code_q <= ErrBadOpcode;
            end
          end
        end
        StAddr: begin
          if (rx_fire) begin
            addr_q <= addr_shift;
            acnt_q <= acnt_q + 1'b1;
            if (acnt_q == LastAddr) begin
              if (mode_wr_q) begin
                wr_addr_q <= addr_shift;
                wr_stb_q  <= 1'b1;
                state_q   <= StIssueWr;
              end else begin
                rd_addr_q <= addr_shift;
                rd_stb_q  <= 1'b1;
                state_q   <= StIssueRd;
              end
            end
          end else if (tmr_expire) begin
            err_stb_q  <= 1'b1;
            err_code_q <= ErrAddrTimeout;
            state_q    <= StIdle;
          end
        end
        StIssueWr: begin
          if (wr_ack_i) begin
            wr_stb_q <= 1'b0;
            bcnt_q   <= '0;
            state_q  <= StWdata;
          end
        end
        StIssueRd: begin
          if (rd_ack_i) begin
            rd_stb_q <= 1'b0;
            state_q  <= StIdle;
          end
        end
        StWdata: begin
          if (wd_stb_q) begin
            if (wd_ack_i) begin
              wd_stb_q <= 1'b0;
              bcnt_q   <= bcnt_q + 1'b1;
              if (bcnt_q == LastByte) state_q <= StIdle;
            end
          end else if (rx_fire) begin
            wd_data_q <= rx_dat_i;
            wd_stb_q  <= 1'b1;
          end else if (tmr_expire) begin
            wd_data_q <= 8'h00;
            wd_stb_q  <= 1'b1;
            state_q   <= StPad;
          end
        end
        StPad: begin
          // Zero bytes are re-offered back to back until the block is complete.
          if (wd_ack_i) begin
            bcnt_q <= bcnt_q + 1'b1;
            if (bcnt_q == LastByte) begin
              wd_stb_q   <= 1'b0;
              err_stb_q  <= 1'b1;
              err_code_q <= ErrDataTimeout;
              state_q    <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wr_stb_o   = wr_stb_q;
  assign wr_addr_o  = wr_addr_q;
  assign rd_stb_o   = rd_stb_q;
  assign rd_addr_o  = rd_addr_q;
  assign wd_stb_o   = wd_stb_q;
  assign wd_data_o  = wd_data_q;
  assign err_stb_o  = err_stb_q;
  assign err_code_o = err_code_q;
  assign busy_o     = (state_q != StIdle);

endmodule

// File: tb/tb_card_cmd_parser.sv
// Self-checking bench: table of commands, timeout boundary and reset sequences, then random
// command streams checked against a command-level model of the expected request events.
module tb_card_cmd_parser;

  localparam int unsigned AB = 4;
  localparam int unsigned BL = 4;
  localparam int unsigned TO = 100;
  localparam logic [7:0] OpWr = 8'h57;
  localparam logic [7:0] OpRd = 8'h52;

  localparam int KRd = 0, KWr = 1, KBad = 2, KAto = 3, KDto = 4;
  localparam logic [1:0] EvRd = 2'd0, EvWr = 2'd1, EvWd = 2'd2, EvErr = 2'd3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_stb = 1'b0;
  logic [7:0]  rx_dat = 8'h00;
  logic        rx_ack;
  logic        wr_stb, wd_stb, rd_stb, err_stb, busy;
  logic [31:0] wr_addr, rd_addr;
  logic [7:0]  wd_data;
  logic [1:0]  err_code;
  logic        wr_ack = 1'b1;
  logic        rd_ack = 1'b1;
  logic        wd_ack = 1'b0;

  always #5 clk = ~clk;

  card_cmd_parser #(
    .ADDR_BYTES (AB),
    .BLOCK_LEN  (BL),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .rx_stb_i  (rx_stb),
    .rx_dat_i  (rx_dat),
    .rx_ack_o  (rx_ack),
    .wr_stb_o  (wr_stb),
    .wr_addr_o (wr_addr),
    .wr_ack_i  (wr_ack),
    .wd_stb_o  (wd_stb),
    .wd_data_o (wd_data),
    .wd_ack_i  (wd_ack),
    .rd_stb_o  (rd_stb),
    .rd_addr_o (rd_addr),
    .rd_ack_i  (rd_ack),
    .err_stb_o (err_stb),
    .err_code_o(err_code),
    .busy_o    (busy)
  );

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] val;
  } ev_t;

  typedef struct {
    int          kind;
    logic [7:0]  op;
    logic [31:0] addr;
    int          nb;
    logic [31:0] data;
    int          stall;
    int          gap;
    logic [1:0]  exp_err;
    int          exp_n;
  } cmd_t;

  ev_t obs[$];
  ev_t exp_q[$];
  int total = 0;
  int bad = 0;
  int overlap = 0;
  int wd_stall = 0;
  int stall_cnt = 0;
  logic wd_hs_seen = 1'b0;
  logic [1:0] model_err = 2'd0;

  function automatic ev_t mk(input logic [1:0] k, input logic [31:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    return e;
  endfunction

  // Observe handshakes on the falling edge, where everything is settled for the next rise.
  always @(negedge clk) begin
    wd_hs_seen = 1'b0;
    if (!rst) begin
      if (rd_stb && rd_ack) obs.push_back(mk(EvRd, rd_addr));
      if (wr_stb && wr_ack) obs.push_back(mk(EvWr, wr_addr));
      if (wd_stb && wd_ack) begin
        obs.push_back(mk(EvWd, {24'd0, wd_data}));
        wd_hs_seen = 1'b1;
      end
      if (err_stb) obs.push_back(mk(EvErr, {30'd0, err_code}));
      if (wd_stb && rx_ack) overlap++;
    end
  end

  // Card-driver data sink: holds WD_ACK low for wd_stall cycles of each offered byte.
  always @(posedge clk) begin
    #1;
    if (!wd_stb || wd_hs_seen) stall_cnt = 0;
    if (wd_stb) begin
      wd_ack = (stall_cnt >= wd_stall);
      stall_cnt++;
    end else begin
      wd_ack = 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic send_gap(input int g);
    repeat (g) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_stb = 1'b1;
    rx_dat = b;
    @(negedge clk);
    while (!rx_ack && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("rx accept", rx_ack, 1'b1);
    @(posedge clk);
    #1;
    rx_stb = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle wait", busy, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_events(input string tag);
    ev_t o, e;
    check({tag, " nevents"}, obs.size(), exp_q.size());
    while (obs.size() > 0 && exp_q.size() > 0) begin
      o = obs.pop_front();
      e = exp_q.pop_front();
      check({tag, " event"}, {o.kind, o.val}, {e.kind, e.val});
    end
    obs.delete();
    exp_q.delete();
  endtask

  // Expected request/data/error events for one command, derived from its description alone.
  task automatic model(input cmd_t c);
    case (c.kind)
      KRd: exp_q.push_back(mk(EvRd, c.addr));
      KWr: begin
        exp_q.push_back(mk(EvWr, c.addr));
        for (int i = 0; i < BL; i++) exp_q.push_back(mk(EvWd, {24'd0, c.data[31-8*i -: 8]}));
      end
      KBad: begin
        exp_q.push_back(mk(EvErr, 32'd1));
        model_err = 2'd1;
      end
      KAto: begin
        exp_q.push_back(mk(EvErr, 32'd2));
        model_err = 2'd2;
      end
      default: begin
        exp_q.push_back(mk(EvWr, c.addr));
        for (int i = 0; i < BL; i++)
          exp_q.push_back(mk(EvWd, (i < c.nb) ? {24'd0, c.data[31-8*i -: 8]} : 32'd0));
        exp_q.push_back(mk(EvErr, 32'd3));
        model_err = 2'd3;
      end
    endcase
  endtask

  task automatic run_cmd(input cmd_t c);
    int na, nd;
    wd_stall = c.stall;
    model(c);
    if (c.kind == KBad) begin
      send_byte(c.op);
    end else begin
      send_byte((c.kind == KRd) ? OpRd : (c.kind == KAto) ? c.op : OpWr);
      na = (c.kind == KAto) ? c.nb : AB;
      for (int i = 0; i < na; i++) begin
        send_gap(c.gap);
        send_byte(c.addr[31-8*i -: 8]);
      end
      if (c.kind == KWr || c.kind == KDto) begin
        nd = (c.kind == KWr) ? BL : c.nb;
        for (int i = 0; i < nd; i++) begin
          send_gap(c.gap);
          send_byte(c.data[31-8*i -: 8]);
        end
      end
    end
    wait_idle();
  endtask

  initial begin
    cmd_t tbl[7];
    cmd_t c;
    tbl[0] = '{KRd,  8'h52, 32'h0000012A, 0, 32'h0,        0,   0, 2'd0, 1};
    tbl[1] = '{KWr,  8'h57, 32'h00000010, 0, 32'hAABBCCDD, 3,   0, 2'd0, 5};
    tbl[2] = '{KBad, 8'h41, 32'h0,        0, 32'h0,        0,   0, 2'd1, 1};
    tbl[3] = '{KRd,  8'h52, 32'hDEADBEEF, 0, 32'h0,        0,   2, 2'd1, 1};
    tbl[4] = '{KAto, 8'h57, 32'h12000000, 1, 32'h0,        0,   0, 2'd2, 1};
    tbl[5] = '{KDto, 8'h57, 32'h00000020, 2, 32'hAABB0000, 0,   0, 2'd3, 6};
    tbl[6] = '{KWr,  8'h57, 32'h00000030, 0, 32'h01020304, 150, 1, 2'd3, 5};

    // Reset state
    #12;
    check("reset wr_stb", wr_stb, 1'b0);
    check("reset rd_stb", rd_stb, 1'b0);
    check("reset wd_stb", wd_stb, 1'b0);
    check("reset err_stb", err_stb, 1'b0);
    check("reset addrs", {wr_addr, rd_addr, wd_data}, 72'd0);
    check("reset err_code", err_code, 2'd0);
    check("reset busy", busy, 1'b0);
    check("reset rx_ack", rx_ack, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int t = 0; t < 7; t++) begin
      run_cmd(tbl[t]);
      check($sformatf("tbl%0d count", t), obs.size(), tbl[t].exp_n);
      check_events($sformatf("tbl%0d", t));
      check($sformatf("tbl%0d err_code", t), err_code, tbl[t].exp_err);
      check($sformatf("tbl%0d busy", t), busy, 1'b0);
    end
    model_err = 2'd3;

    // Address byte landing on the exact expiry cycle wins.
    send_byte(OpRd);
    send_byte(8'hC1);
    send_gap(TO - 1);
    send_byte(8'hC2);
    send_byte(8'hC3);
    send_byte(8'hC4);
    wait_idle();
    exp_q.push_back(mk(EvRd, 32'hC1C2C3C4));
    check_events("byte wins");
    check("byte wins err_code", err_code, 2'd3);

    // One cycle later the timeout fires and the byte is taken as a fresh opcode.
    send_byte(OpWr);
    send_gap(TO);
    send_byte(OpRd);
    for (int i = 0; i < AB; i++) send_byte(8'h70 + 8'(i));
    wait_idle();
    exp_q.push_back(mk(EvErr, 32'd2));
    exp_q.push_back(mk(EvRd, 32'h70717273));
    check_events("late byte");
    check("late byte err_code", err_code, 2'd2);

    // Asynchronous reset in the middle of a payload.
    wd_stall = 0;
    send_byte(OpWr);
    for (int i = 0; i < AB; i++) send_byte((i == AB - 1) ? 8'h40 : 8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b1;
    #1;
    check("async rst stbs", {wr_stb, rd_stb, wd_stb, err_stb, busy}, 5'd0);
    check("async rst data", {wd_data, err_code}, 10'd0);
    send_gap(3);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_gap(2 * TO);
    exp_q.push_back(mk(EvWr, 32'h40));
    exp_q.push_back(mk(EvWd, 32'hAA));
    check_events("rst mid");
    model_err = 2'd0;
    c = '{KWr, 8'h57, 32'h00000050, 0, 32'h11223344, 1, 0, 2'd0, 5};
    run_cmd(c);
    check_events("post rst");
    check("post rst err_code", err_code, 2'd0);

    // Random command stream
    for (int r = 0; r < 40; r++) begin
      int k;
      k = int'($urandom_range(0, 9));
      c.addr = $urandom;
      c.data = $urandom;
      c.stall = int'($urandom_range(0, 4));
      c.gap = int'($urandom_range(0, 6));
      c.nb = 0;
      c.op = OpWr;
      c.exp_err = 2'd0;
      c.exp_n = 0;
      if (k < 3) c.kind = KRd;
      else if (k < 6) c.kind = KWr;
      else if (k == 6) begin
        c.kind = KBad;
        c.op = 8'($urandom_range(0, 255));
        while (c.op == OpWr || c.op == OpRd) c.op = 8'($urandom_range(0, 255));
      end else if (k == 7) begin
        c.kind = KAto;
        c.op = $urandom_range(0, 1) ? OpWr : OpRd;
        c.nb = int'($urandom_range(0, AB - 1));
      end else begin
        c.kind = KDto;
        c.nb = int'($urandom_range(0, BL - 1));
      end
      send_gap(int'($urandom_range(0, 3)));
      run_cmd(c);
      check_events($sformatf("rand%0d", r));
      check($sformatf("rand%0d err_code", r), err_code, model_err);
    end

    check("rx/wd overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
